// File: rtl/nios_i2c_pkg.sv
// Shared types and constants for the Nios I2C master.
// States, register addresses and command bit positions.
package nios_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_e;

  localparam logic [1:0] ADDR_CMD = 2'd0;
  localparam logic [1:0] ADDR_TX  = 2'd1;
  localparam logic [1:0] ADDR_RX  = 2'd2;
  localparam logic [1:0] ADDR_DIV = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_WRITE = 2;
  localparam int CMD_READ  = 3;
  localparam int CMD_NACK  = 4;

endpackage

// File: rtl/nios_i2c_qtick.sv
// Quarter-bit timer: reloads from the divisor, holds while stalled.
// Ticks on the last cycle of each DIVISOR+1 cycle quarter.
module nios_i2c_qtick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reload,
  input  logic             stall,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload || stall) begin
      cnt_d = divisor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0) && !stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nios_i2c_master_ctrl.sv
// Avalon-MM I2C master: START / byte / STOP sequencing of SCL and SDA.
// Drives open-drain enables; busy is simply "FSM not idle".
module nios_i2c_master_ctrl
  import nios_i2c_pkg::*;
#(
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = 16'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  state_e           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             nack_q, nack_d;
  logic             f_stop_q, f_stop_d;
  logic             f_byte_q, f_byte_d;
  logic             f_write_q, f_write_d;
  logic             f_nack_q, f_nack_d;
  logic             scl_oe_q, scl_d;
  logic             sda_oe_q, sda_d;
  logic             reload, stall, tick;
  logic             wr_en, wr_cmd, wr_tx, wr_div;
  logic             busy;
  logic             unused_wd;

  assign wr_en  = chipselect && !write_n;
  assign wr_cmd = wr_en && (address == ADDR_CMD);
  assign wr_tx  = wr_en && (address == ADDR_TX);
  assign wr_div = wr_en && (address == ADDR_DIV);
  assign busy   = (state_q != ST_IDLE);
  assign unused_wd = ^writedata[31:DIV_W];

  // Only the SCL-high phases wait for the line to actually rise.
  always_comb begin
    stall = 1'b0;
    if (!scl_in) begin
      stall = ((state_q == ST_START) && (ph_q == 2'd1)) ||
              ((state_q inside {ST_BIT, ST_ACK, ST_STOP}) &&
               (ph_q == 2'd2));
    end
  end

  nios_i2c_qtick #(.DIV_W(DIV_W)) u_qtick (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (reload),
    .stall   (stall),
    .divisor (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    div_d     = div_q;
    nack_d    = nack_q;
    f_stop_d  = f_stop_q;
    f_byte_d  = f_byte_q;
    f_write_d = f_write_q;
    f_nack_d  = f_nack_q;
    reload    = 1'b0;
    if (wr_tx) tx_d = writedata[7:0];
    if (wr_div) div_d = writedata[DIV_W-1:0];
    if (state_q == ST_IDLE) begin
      if (wr_cmd && (|writedata[3:0])) begin
        reload    = 1'b1;
        ph_d      = 2'd0;
        bit_d     = 3'd7;
        f_stop_d  = writedata[CMD_STOP];
        f_write_d = writedata[CMD_WRITE];
        f_byte_d  = writedata[CMD_WRITE] | writedata[CMD_READ];
        f_nack_d  = writedata[CMD_NACK];
        if (writedata[CMD_START]) state_d = ST_START;
        else if (f_byte_d)        state_d = ST_BIT;
        else                      state_d = ST_STOP;
      end
    end else if (tick) begin
      reload = 1'b1;
      ph_d   = ph_q + 2'd1;
      if (ph_q == 2'd2 && state_q == ST_BIT)
        sh_d = {sh_q[6:0], sda_in};
      if (ph_q == 2'd2 && state_q == ST_ACK && f_write_q)
        nack_d = sda_in;
      if (ph_q == 2'd3) begin
        case (state_q)
          ST_START: begin
            bit_d = 3'd7;
            if (f_byte_q)      state_d = ST_BIT;
            else if (f_stop_q) state_d = ST_STOP;
            else               state_d = ST_IDLE;
          end
          ST_BIT: begin
            if (bit_q == 3'd0) state_d = ST_ACK;
            else               bit_d = bit_q - 3'd1;
          end
          ST_ACK: begin
            if (!f_write_q) rx_d = sh_q;
            state_d = f_stop_q ? ST_STOP : ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Line levels are a pure function of the phase being entered.
  always_comb begin
    scl_d = scl_oe_q;
    sda_d = sda_oe_q;
    case (state_d)
      ST_START: begin
        scl_d = (ph_d == 2'd3);
        sda_d = ph_d[1];
      end
      ST_BIT: begin
        scl_d = (ph_d == 2'd0) || (ph_d == 2'd3);
        sda_d = f_write_d & ~tx_q[bit_d];
      end
      ST_ACK: begin
        scl_d = (ph_d == 2'd0) || (ph_d == 2'd3);
        sda_d = ~f_write_d & ~f_nack_d;
      end
      ST_STOP: begin
        scl_d = (ph_d == 2'd0);
        sda_d = (ph_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ph_q      <= 2'd0;
      bit_q     <= 3'd7;
      sh_q      <= 8'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      div_q     <= DIV_DEFAULT;
      nack_q    <= 1'b0;
      f_stop_q  <= 1'b0;
      f_byte_q  <= 1'b0;
      f_write_q <= 1'b0;
      f_nack_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      nack_q    <= nack_d;
      f_stop_q  <= f_stop_d;
      f_byte_q  <= f_byte_d;
      f_write_q <= f_write_d;
      f_nack_q  <= f_nack_d;
      scl_oe_q  <= scl_d;
      sda_oe_q  <= sda_d;
    end
  end

  // Lines release as soon as reset is asserted, not one edge later.
  assign scl_oe = scl_oe_q & reset_n;
  assign sda_oe = sda_oe_q & reset_n;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CMD: readdata = {30'd0, nack_q, busy};
      ADDR_TX:  readdata = {24'd0, tx_q};
      ADDR_RX:  readdata = {24'd0, rx_q};
      default:  readdata = {{(32 - DIV_W){1'b0}}, div_q};
    endcase
  end

endmodule
